// File: rtl/mxint_accumulator_flex_if.sv
// Stream bus for the MxInt block accumulator: MxInt beats in, wide block result out.
interface mxint_accumulator_flex_if #(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 4,
    parameter int unsigned BLOCK_SIZE             = 4,
    parameter int unsigned MAX_DEPTH              = 16,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + (2 ** DATA_IN_0_PRECISION_1)
                                                    + $clog2(MAX_DEPTH),
    parameter int unsigned DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1 + $clog2($clog2(MAX_DEPTH) + 1)
);
    localparam int unsigned COUNTER_WIDTH = $clog2(MAX_DEPTH + 1);

    logic [COUNTER_WIDTH-1:0]                             cfg_depth;
    logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]     mdata_in_0;
    logic [DATA_IN_0_PRECISION_1-1:0]                     edata_in_0;
    logic                                                 data_in_0_last;
    logic                                                 data_in_0_valid;
    logic                                                 data_in_0_ready;
    logic [BLOCK_SIZE-1:0][DATA_OUT_0_PRECISION_0-1:0]    mdata_out_0;
    logic [DATA_OUT_0_PRECISION_1-1:0]                    edata_out_0;
    logic                                                 data_out_0_valid;
    logic                                                 data_out_0_ready;
    logic [COUNTER_WIDTH-1:0]                             accum_count;

    modport slave (
        input  cfg_depth, mdata_in_0, edata_in_0, data_in_0_last, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, mdata_out_0, edata_out_0, data_out_0_valid, accum_count
    );

    modport master (
        output cfg_depth, mdata_in_0, edata_in_0, data_in_0_last, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, mdata_out_0, edata_out_0, data_out_0_valid, accum_count
    );
endinterface

// File: rtl/mxint_accumulator_flex.sv
// MxInt block accumulator: aligns each beat to the running maximum exponent and
// sums it into a wide per-lane accumulator; block length set per block at runtime.
module mxint_accumulator_flex #(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 4,
    parameter int unsigned BLOCK_SIZE             = 4,
    parameter int unsigned MAX_DEPTH              = 16,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + (2 ** DATA_IN_0_PRECISION_1)
                                                    + $clog2(MAX_DEPTH),
    parameter int unsigned DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1 + $clog2($clog2(MAX_DEPTH) + 1)
) (
    input logic                   clk,
    input logic                   rst,
    mxint_accumulator_flex_if.slave bus
);
    localparam int unsigned P0_IN         = DATA_IN_0_PRECISION_0;
    localparam int unsigned P1_IN         = DATA_IN_0_PRECISION_1;
    localparam int unsigned P0_OUT        = DATA_OUT_0_PRECISION_0;
    localparam int unsigned P1_OUT        = DATA_OUT_0_PRECISION_1;
    localparam int unsigned COUNTER_WIDTH = $clog2(MAX_DEPTH + 1);
    localparam int unsigned LEFT_PADDING  = $clog2(MAX_DEPTH);
    localparam int unsigned RIGHT_PADDING = 2 ** P1_IN;
    localparam int          EXP_IN_BIAS   = (2 ** (P1_IN - 1)) - 1;
    localparam int          EXP_OUT_BIAS  = (2 ** (P1_OUT - 1)) - 1;
    localparam int          EXP_OFFSET    = EXP_OUT_BIAS - EXP_IN_BIAS + int'(LEFT_PADDING);

    typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;

    state_t                             state_q, state_next;
    logic [COUNTER_WIDTH-1:0]           depth_q, depth_next;
    logic [COUNTER_WIDTH-1:0]           count_q, count_next;
    logic [COUNTER_WIDTH-1:0]           depth_cfg;
    logic [P1_IN-1:0]                   max_exp_q, exp_next;
    logic [P1_OUT-1:0]                  edata_q, edata_next;
    logic [BLOCK_SIZE-1:0][P0_OUT-1:0]  acc_q, acc_next;
    logic                               valid_q;
    logic signed [P1_IN:0]              exp_diff;
    logic [P1_IN-1:0]                   shamt;
    logic                               in_ready_c;
    logic                               in_fire;
    logic                               first_beat;
    logic                               close;

    // Sign-extend a mantissa into the wide accumulator frame with fractional headroom.
    function automatic logic signed [P0_OUT-1:0] pad_lane(input logic [P0_IN-1:0] m);
        return {{(P0_OUT - P0_IN - RIGHT_PADDING){m[P0_IN-1]}}, m, {RIGHT_PADDING{1'b0}}};
    endfunction

    assign in_ready_c           = (state_q != FULL) || bus.data_out_0_ready;
    assign bus.data_in_0_ready  = in_ready_c;
    assign bus.data_out_0_valid = valid_q;
    assign bus.mdata_out_0      = acc_q;
    assign bus.edata_out_0      = edata_q;
    assign bus.accum_count      = count_q;

    // Next-state and datapath update for one accepted beat or an output drain.
    always_comb begin
        state_next = state_q;
        depth_next = depth_q;
        count_next = count_q;
        exp_next   = max_exp_q;
        edata_next = edata_q;
        acc_next   = acc_q;
        close      = 1'b0;

        exp_diff   = $signed({1'b0, max_exp_q}) - $signed({1'b0, bus.edata_in_0});
        shamt      = exp_diff[P1_IN] ? P1_IN'(-exp_diff) : P1_IN'(exp_diff);

        depth_cfg  = bus.cfg_depth;
        if (bus.cfg_depth == '0) begin
            depth_cfg = COUNTER_WIDTH'(1);
        end else if (bus.cfg_depth > COUNTER_WIDTH'(MAX_DEPTH)) begin
            depth_cfg = COUNTER_WIDTH'(MAX_DEPTH);
        end

        in_fire    = bus.data_in_0_valid && in_ready_c;
        first_beat = in_fire && (state_q != ACCUM);

        if (first_beat) begin
            depth_next = depth_cfg;
            count_next = COUNTER_WIDTH'(1);
            exp_next   = bus.edata_in_0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                acc_next[i] = pad_lane(bus.mdata_in_0[i]);
            end
            close = (depth_cfg == COUNTER_WIDTH'(1)) || bus.data_in_0_last;
        end else if (in_fire) begin
            count_next = count_q + COUNTER_WIDTH'(1);
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                if (!exp_diff[P1_IN]) begin
                    acc_next[i] = $signed(acc_q[i]) + (pad_lane(bus.mdata_in_0[i]) >>> shamt);
                end else begin
                    acc_next[i] = ($signed(acc_q[i]) >>> shamt) + pad_lane(bus.mdata_in_0[i]);
                end
            end
            if (exp_diff[P1_IN]) begin
                exp_next = bus.edata_in_0;
            end
            close = (count_next == depth_q) || bus.data_in_0_last;
        end else if ((state_q == FULL) && bus.data_out_0_ready) begin
            state_next = IDLE;
            count_next = '0;
            exp_next   = '0;
            edata_next = '0;
            acc_next   = '0;
        end

        if (in_fire) begin
            state_next = close ? FULL : ACCUM;
            edata_next = P1_OUT'(exp_next) + P1_OUT'(EXP_OFFSET);
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            depth_q   <= '0;
            count_q   <= '0;
            max_exp_q <= '0;
            edata_q   <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_next;
            depth_q   <= depth_next;
            count_q   <= count_next;
            max_exp_q <= exp_next;
            edata_q   <= edata_next;
            acc_q     <= acc_next;
            valid_q   <= (state_next == FULL);
        end
    end
endmodule

// File: tb/tb_mxint_accumulator_flex.sv
// Self-checking bench for mxint_accumulator_flex: directed scenarios plus a
// randomized stream compared against a block-level arithmetic model.
module tb_mxint_accumulator_flex;
    localparam int unsigned P0  = 8;
    localparam int unsigned P1  = 4;
    localparam int unsigned BS  = 4;
    localparam int unsigned MD  = 16;
    localparam int unsigned P0O = 28;
    localparam int unsigned P1O = 7;
    localparam int unsigned CW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mxint_accumulator_flex_if #(
        .DATA_IN_0_PRECISION_0(P0), .DATA_IN_0_PRECISION_1(P1),
        .BLOCK_SIZE(BS), .MAX_DEPTH(MD)
    ) bus ();

    mxint_accumulator_flex #(
        .DATA_IN_0_PRECISION_0(P0), .DATA_IN_0_PRECISION_1(P1),
        .BLOCK_SIZE(BS), .MAX_DEPTH(MD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus copies (what the bench is driving this cycle)
    bit         s_valid, s_last, s_ordy;
    int         s_cfg, s_e;
    logic [7:0] s_m [BS];

    // Block-level reference model
    bit     m_full;
    int     m_full_n, m_full_mx;
    longint m_full_acc [BS];
    int     m_open_n, m_open_mx, m_depth;
    longint m_open_acc [BS];

    function automatic longint pad(logic [7:0] m);
        longint v;
        v = longint'($signed(m));
        return v * 65536;
    endfunction

    function automatic longint exp_acc(int i);
        if (m_full) return m_full_acc[i];
        if (m_open_n > 0) return m_open_acc[i];
        return 0;
    endfunction

    function automatic int exp_edata();
        if (m_full) return m_full_mx + 60;
        if (m_open_n > 0) return m_open_mx + 60;
        return 0;
    endfunction

    function automatic int exp_count();
        return m_full ? m_full_n : m_open_n;
    endfunction

    task automatic model_beat();
        if (m_open_n == 0) begin
            m_depth = (s_cfg == 0) ? 1 : ((s_cfg > int'(MD)) ? int'(MD) : s_cfg);
            for (int i = 0; i < int'(BS); i++) m_open_acc[i] = pad(s_m[i]);
            m_open_mx = s_e;
        end else if (s_e <= m_open_mx) begin
            for (int i = 0; i < int'(BS); i++) m_open_acc[i] += pad(s_m[i]) >>> (m_open_mx - s_e);
        end else begin
            for (int i = 0; i < int'(BS); i++) m_open_acc[i] = (m_open_acc[i] >>> (s_e - m_open_mx)) + pad(s_m[i]);
            m_open_mx = s_e;
        end
        m_open_n++;
        if (m_open_n == m_depth || s_last) begin
            m_full     = 1'b1;
            m_full_n   = m_open_n;
            m_full_mx  = m_open_mx;
            m_full_acc = m_open_acc;
            m_open_n   = 0;
        end
    endtask

    task automatic apply();
        bus.data_in_0_valid  = s_valid;
        bus.data_in_0_last   = s_last;
        bus.cfg_depth        = CW'(s_cfg);
        for (int i = 0; i < int'(BS); i++) bus.mdata_in_0[i] = s_m[i];
        bus.edata_in_0       = P1'(s_e);
        bus.data_out_0_ready = s_ordy;
    endtask

    task automatic set_uni(bit v, bit l, int cfg, int m, int e, bit ordy);
        s_valid = v; s_last = l; s_cfg = cfg; s_e = e; s_ordy = ordy;
        for (int i = 0; i < int'(BS); i++) s_m[i] = 8'(m);
        apply();
    endtask

    // Advance one clock edge, updating the model from the stimulus presented at it
    task automatic tick();
        bit in_fire, out_fire;
        in_fire  = s_valid && (!m_full || s_ordy);
        out_fire = m_full && s_ordy;
        @(posedge clk);
        if (!rst) begin
            m_full   = 1'b0;
            m_open_n = 0;
        end else begin
            if (out_fire) m_full = 1'b0;
            if (in_fire) model_beat();
        end
        #1;
    endtask

    task automatic drain();
        set_uni(0, 0, 0, 0, 0, 1);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_uni(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.data_out_0_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.data_out_0_valid); end
        n_cmp++; if (bus.data_in_0_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", bus.data_in_0_ready); end
        n_cmp++; if (bus.accum_count !== CW'(0)) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.accum_count); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(0)) begin n_bad++; $display("FAIL reset_edata: got %0d want 0", bus.edata_out_0); end
        for (int i = 0; i < int'(BS); i++) begin
            n_cmp++; if (bus.mdata_out_0[i] !== P0O'(0)) begin n_bad++; $display("FAIL reset_mdata lane%0d: got %0d want 0", i, bus.mdata_out_0[i]); end
        end
    endtask

    // Two-beat block; checks valid/mantissa/exponent/count after closing beat
    task automatic test_pair(string name, int m0, int e0, int m1, int e1, int want_m, int want_e);
        logic [P0O-1:0] want;
        want = P0O'(want_m);
        set_uni(1, 0, 2, m0, e0, 0);
        tick();
        set_uni(1, 0, 2, m1, e1, 0);
        tick();
        set_uni(0, 0, 2, 0, 0, 0);
        n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %0b want 1", name, bus.data_out_0_valid); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(want_e)) begin n_bad++; $display("FAIL %s_edata: got %0d want %0d", name, bus.edata_out_0, want_e); end
        n_cmp++; if (bus.accum_count !== CW'(2)) begin n_bad++; $display("FAIL %s_count: got %0d want 2", name, bus.accum_count); end
        for (int i = 0; i < int'(BS); i++) begin
            n_cmp++; if (bus.mdata_out_0[i] !== want) begin n_bad++; $display("FAIL %s_mdata lane%0d: got %0d want %0d", name, i, $signed(bus.mdata_out_0[i]), want_m); end
        end
        drain();
    endtask

    task automatic test_alignment();
        test_pair("basic", 1, 7, 1, 7, 131072, 67);
        test_pair("align_up", 4, 5, 1, 7, 131072, 67);
        test_pair("align_down", 1, 7, 4, 5, 131072, 67);
        test_pair("negative", -1, 7, -1, 6, -98304, 67);
    endtask

    task automatic test_last();
        for (int b = 0; b < 3; b++) begin
            set_uni(1, (b == 2), 8, 1, 7, 0);
            tick();
            if (b == 1) begin
                n_cmp++; if (bus.data_out_0_valid !== 1'b0) begin n_bad++; $display("FAIL last_early_valid: got %0b want 0", bus.data_out_0_valid); end
                n_cmp++; if (bus.accum_count !== CW'(2)) begin n_bad++; $display("FAIL last_partial_count: got %0d want 2", bus.accum_count); end
            end
        end
        n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL last_valid: got %0b want 1", bus.data_out_0_valid); end
        n_cmp++; if (bus.accum_count !== CW'(3)) begin n_bad++; $display("FAIL last_count: got %0d want 3", bus.accum_count); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(67)) begin n_bad++; $display("FAIL last_edata: got %0d want 67", bus.edata_out_0); end
        for (int i = 0; i < int'(BS); i++) begin
            n_cmp++; if (bus.mdata_out_0[i] !== P0O'(196608)) begin n_bad++; $display("FAIL last_mdata lane%0d: got %0d want 196608", i, $signed(bus.mdata_out_0[i])); end
        end
        drain();
    endtask

    task automatic test_depth_zero();
        int ms [2] = '{3, -2};
        for (int b = 0; b < 2; b++) begin
            set_uni(1, 0, 0, ms[b], 7, 1);
            tick();
            n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL depth0_valid beat%0d: got %0b want 1", b, bus.data_out_0_valid); end
            n_cmp++; if (bus.accum_count !== CW'(1)) begin n_bad++; $display("FAIL depth0_count beat%0d: got %0d want 1", b, bus.accum_count); end
            n_cmp++; if (bus.mdata_out_0[0] !== P0O'(ms[b] * 65536)) begin n_bad++; $display("FAIL depth0_mdata beat%0d: got %0d want %0d", b, $signed(bus.mdata_out_0[0]), ms[b] * 65536); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_uni(1, 0, 2, 1, 7, 0);
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            set_uni(1, 0, 2, 2, 7, 0);
            #1;
            n_cmp++; if (bus.data_in_0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready cyc%0d: got %0b want 0", c, bus.data_in_0_ready); end
            tick();
            n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid cyc%0d: got %0b want 1", c, bus.data_out_0_valid); end
            n_cmp++; if (bus.accum_count !== CW'(2)) begin n_bad++; $display("FAIL bp_count cyc%0d: got %0d want 2", c, bus.accum_count); end
            n_cmp++; if (bus.edata_out_0 !== P1O'(67)) begin n_bad++; $display("FAIL bp_edata cyc%0d: got %0d want 67", c, bus.edata_out_0); end
            n_cmp++; if (bus.mdata_out_0[c] !== P0O'(131072)) begin n_bad++; $display("FAIL bp_mdata cyc%0d: got %0d want 131072", c, $signed(bus.mdata_out_0[c])); end
        end
        set_uni(1, 0, 2, 2, 7, 1);
        tick();
        n_cmp++; if (bus.data_out_0_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %0b want 0", bus.data_out_0_valid); end
        n_cmp++; if (bus.accum_count !== CW'(1)) begin n_bad++; $display("FAIL bp_release_count: got %0d want 1", bus.accum_count); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(67)) begin n_bad++; $display("FAIL bp_release_edata: got %0d want 67", bus.edata_out_0); end
        n_cmp++; if (bus.mdata_out_0[3] !== P0O'(131072)) begin n_bad++; $display("FAIL bp_release_mdata: got %0d want 131072", $signed(bus.mdata_out_0[3])); end
    endtask

    task automatic test_reset_mid_block();
        set_uni(1, 0, 4, 5, 9, 1);
        tick();
        rst = 1'b0;
        set_uni(0, 0, 4, 0, 0, 1);
        tick();
        rst = 1'b1;
        n_cmp++; if (bus.data_out_0_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b want 0", bus.data_out_0_valid); end
        n_cmp++; if (bus.accum_count !== CW'(0)) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", bus.accum_count); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(0)) begin n_bad++; $display("FAIL rstmid_edata: got %0d want 0", bus.edata_out_0); end
        n_cmp++; if (bus.mdata_out_0[0] !== P0O'(0)) begin n_bad++; $display("FAIL rstmid_mdata: got %0d want 0", $signed(bus.mdata_out_0[0])); end
        for (int b = 0; b < 4; b++) begin
            set_uni(1, 0, 4, 1, 7, 1);
            tick();
            if (b == 2) begin
                n_cmp++; if (bus.data_out_0_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_early_valid: got %0b want 0", bus.data_out_0_valid); end
            end
        end
        set_uni(0, 0, 4, 0, 0, 0);
        n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_block_valid: got %0b want 1", bus.data_out_0_valid); end
        n_cmp++; if (bus.accum_count !== CW'(4)) begin n_bad++; $display("FAIL rstmid_block_count: got %0d want 4", bus.accum_count); end
        n_cmp++; if (bus.edata_out_0 !== P1O'(67)) begin n_bad++; $display("FAIL rstmid_block_edata: got %0d want 67", bus.edata_out_0); end
        n_cmp++; if (bus.mdata_out_0[1] !== P0O'(262144)) begin n_bad++; $display("FAIL rstmid_block_mdata: got %0d want 262144", $signed(bus.mdata_out_0[1])); end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 6; b++) begin
            set_uni(1, 0, 1, b * 7 - 20, 7, 1);
            #1;
            n_cmp++; if (bus.data_in_0_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready beat%0d: got %0b want 1", b, bus.data_in_0_ready); end
            tick();
            n_cmp++; if (bus.data_out_0_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid beat%0d: got %0b want 1", b, bus.data_out_0_valid); end
            n_cmp++; if (bus.mdata_out_0[2] !== P0O'((b * 7 - 20) * 65536)) begin n_bad++; $display("FAIL b2b_mdata beat%0d: got %0d want %0d", b, $signed(bus.mdata_out_0[2]), (b * 7 - 20) * 65536); end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_last  = ($urandom_range(0, 7) == 0);
            s_cfg   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 31));
            s_e     = int'($urandom_range(0, 15));
            s_ordy  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(BS); i++) s_m[i] = 8'($urandom);
            apply();
            rst = ($urandom_range(0, 149) != 0);
            #1;
            n_cmp++; if (bus.data_in_0_ready !== (!m_full || s_ordy)) begin n_bad++; $display("FAIL rand_ready cyc%0d: got %0b want %0b", c, bus.data_in_0_ready, (!m_full || s_ordy)); end
            n_cmp++; if (bus.data_out_0_valid !== m_full) begin n_bad++; $display("FAIL rand_valid cyc%0d: got %0b want %0b", c, bus.data_out_0_valid, m_full); end
            tick();
            n_cmp++; if (bus.accum_count !== CW'(exp_count())) begin n_bad++; $display("FAIL rand_count cyc%0d: got %0d want %0d", c, bus.accum_count, exp_count()); end
            n_cmp++; if (bus.edata_out_0 !== P1O'(exp_edata())) begin n_bad++; $display("FAIL rand_edata cyc%0d: got %0d want %0d", c, bus.edata_out_0, exp_edata()); end
            for (int i = 0; i < int'(BS); i++) begin
                n_cmp++; if (bus.mdata_out_0[i] !== P0O'(exp_acc(i))) begin n_bad++; $display("FAIL rand_mdata cyc%0d lane%0d: got %0d want %0d", c, i, $signed(bus.mdata_out_0[i]), exp_acc(i)); end
            end
        end
        rst = 1'b1;
        drain();
    endtask

    initial begin
        m_full   = 1'b0;
        m_open_n = 0;
        test_reset();
        test_alignment();
        test_last();
        test_depth_zero();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mxint_accumulator_flex.md
# mxint_accumulator_flex

Runtime-configurable MxInt block accumulator: sums a stream of BLOCK_SIZE-wide MxInt beats (shared exponent, signed mantissas) into a wide aligned accumulator, one beat per cycle. The accumulation length comes from a per-block configuration input, up to MAX_DEPTH, and an input `last` flag can end a block early. It sits after the MxInt dot-product/linear datapath and produces the wide block result consumed by the output cast/quantiser.

## Interface
- DATA_IN_0_PRECISION_0, 8, input mantissa width (two's complement)
- DATA_IN_0_PRECISION_1, 4, input exponent width (biased, bias 2^(P1-1)-1)
- BLOCK_SIZE, 4, mantissas per beat
- MAX_DEPTH, 16, maximum beats per accumulation (≥1)
- DATA_OUT_0_PRECISION_0, P0_IN + 2^P1_IN + clog2(MAX_DEPTH), output mantissa width
- DATA_OUT_0_PRECISION_1, P1_IN + clog2(clog2(MAX_DEPTH)+1), output exponent width
- COUNTER_WIDTH (local), clog2(MAX_DEPTH+1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cfg_depth  in  COUNTER_WIDTH  beats per block; sampled on first beat of each block
- mdata_in_0  in  P0_IN x BLOCK_SIZE  input mantissas
- edata_in_0  in  P1_IN  input shared exponent
- data_in_0_last  in  1  beat closes current block regardless of count
- data_in_0_valid  in  1 / data_in_0_ready  out  1  input handshake
- mdata_out_0  out  P0_OUT x BLOCK_SIZE  accumulated mantissas
- edata_out_0  out  P1_OUT  output shared exponent
- data_out_0_valid  out  1 / data_out_0_ready  in  1  output handshake
- accum_count  out  COUNTER_WIDTH  beats accepted in current block

## Operation
- States: IDLE (count 0), ACCUM (0<count<depth_q, not closed), FULL (block closed, data_out_0_valid=1).
- data_in_0_ready = (state != FULL) || data_out_0_ready. data_out_0_valid = (state == FULL).
- First beat of a block (state IDLE, or FULL with out-handshake and in-handshake in same cycle): depth_q <= clamp(cfg_depth), clamp: 0 -> 1, >MAX_DEPTH -> MAX_DEPTH; acc <= padded input; max_exp_q <= edata_in_0; count <= 1.
- Padding: padded = {LEFT_PADDING sign bits, mantissa, RIGHT_PADDING zeros}, LEFT_PADDING = clog2(MAX_DEPTH), RIGHT_PADDING = 2^P1_IN.
- Subsequent beat: d = max_exp_q - edata_in_0 (signed, P1_IN+1 bits). d ≥ 0: acc += padded >>> d. d < 0: acc <= (acc >>> -d) + padded; max_exp_q <= edata_in_0. Arithmetic shifts; acc truncation toward -inf. Input shift is lossless (d ≤ 2^P1_IN-1 < RIGHT_PADDING).
- Block closes (-> FULL) when the accepted beat makes count == depth_q or carries data_in_0_last=1; a first beat with depth_q=1 or last=1 closes immediately.
- edata_out_0 = max_exp_q - EXP_IN_BIAS + EXP_OUT_BIAS + LEFT_PADDING, updated with every accepted beat.
- FULL with ready=1 and no input valid: -> IDLE, acc, exponent, count cleared to 0.
- FULL with ready=0: all outputs held, input stalled (ready=0).
- last on a beat in IDLE with depth_q > 1: block of one beat.
- Per-lane arithmetic independent; all lanes share max_exp_q.

## Timing
- Reset (rst=0 at clk edge): count, mdata_out_0, edata_out_0, max_exp_q, depth_q = 0; state IDLE; data_out_0_valid=0; data_in_0_ready=1 from the first cycle after reset.
- Reset mid-block: partial sum discarded, no output produced.
- Latency: closing beat accepted at edge t -> data_out_0_valid high after edge t, result visible same cycle.
- Throughput: one beat per cycle including back-to-back blocks (output drain and new block's first beat in the same cycle); no bubble.
- Outputs are registers; stable while valid && !ready.
- cfg_depth changes mid-block have no effect until next block's first beat.

## Test plan
Defaults P0=8, P1=4, MAX_DEPTH=16 (P0_OUT=28, P1_OUT=7, LEFT_PADDING=4).
- cfg_depth=2, beats {m=1,e=7},{m=1,e=7} all lanes -> one cycle later valid, mdata=131072 per lane, edata=67, accum_count=2.
- cfg_depth=2, {m=4,e=5} then {m=1,e=7} -> mdata=131072, edata=67; swapped order {m=1,e=7},{m=4,e=5} -> same result.
- Negative: {m=-1,e=7},{m=-1,e=6} -> mdata=-98304, edata=67.
- cfg_depth=8, last=1 on 3rd beat of e=7,m=1 -> valid after 3rd beat, accum_count=3, mdata=196608; cfg_depth=0 -> every beat closes block.
- Backpressure: block full, data_out_0_ready=0 for 3 cycles with input valid -> data_in_0_ready=0, outputs constant; then ready=1 with valid {m=2,e=7} -> next cycle count=1, mdata=131072, edata=67, valid=0 (cfg_depth=2).
- Reset asserted after 1 of 4 beats -> all outputs 0; fresh 4-beat block afterwards gives correct sum with no residue.
